// File: rtl/sa_autosa_cacc_reg_pkg.sv
// Register map, field positions, reset values and shared types for the CACC multi-group config bank.
package sa_autosa_cacc_reg_pkg;

  localparam logic [11:0] OFF_S_STATUS   = 12'h000;
  localparam logic [11:0] OFF_S_POINTER  = 12'h004;
  localparam logic [11:0] OFF_OP_ENABLE  = 12'h008;
  localparam logic [11:0] OFF_MISC       = 12'h00c;
  localparam logic [11:0] OFF_SIZE0      = 12'h010;
  localparam logic [11:0] OFF_SIZE1      = 12'h014;
  localparam logic [11:0] OFF_ADDR       = 12'h018;
  localparam logic [11:0] OFF_BATCH      = 12'h01c;
  localparam logic [11:0] OFF_LINE_STRD  = 12'h020;
  localparam logic [11:0] OFF_SURF_STRD  = 12'h024;
  localparam logic [11:0] OFF_MAP        = 12'h028;
  localparam logic [11:0] OFF_CLIP       = 12'h02c;
  localparam logic [11:0] OFF_SAT        = 12'h030;
  localparam logic [11:0] OFF_CYA        = 12'h034;
  localparam logic [11:0] OFF_S_INTR     = 12'h038;

  localparam int STATUS_WR_ERR_BIT = 16;
  localparam int POINTER_CONS_LSB  = 16;
  localparam int INTR_ERR_BIT      = 16;
  localparam int MISC_PREC_LSB     = 12;
  localparam int SIZE0_H_LSB       = 16;
  localparam int MAP_SURF_BIT      = 16;

  localparam logic [1:0] PREC_RST = 2'b01;

  typedef struct packed {
    logic [1:0]  proc_precision;
    logic        cosa_mode;
    logic        line_packed;
    logic        surf_packed;
    logic [4:0]  batches;
    logic [4:0]  clip_truncate;
    logic [31:0] cya;
  } cacc_ctl_t;

  localparam cacc_ctl_t CTL_RST = '{
    proc_precision: PREC_RST,
    cosa_mode:      1'b0,
    line_packed:    1'b0,
    surf_packed:    1'b0,
    batches:        5'd0,
    clip_truncate:  5'd0,
    cya:            32'd0
  };

  // Writable per-group fields; SAT is read-only and excluded so it never flags a protection error.
  function automatic logic is_group_field(input logic [11:0] off);
    case (off)
      OFF_MISC, OFF_SIZE0, OFF_SIZE1, OFF_ADDR, OFF_BATCH, OFF_LINE_STRD,
      OFF_SURF_STRD, OFF_MAP, OFF_CLIP, OFF_CYA: is_group_field = 1'b1;
      default:                                   is_group_field = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sa_autosa_cacc_reg_group.sv
// One CACC config register group: field flops, write decode for an already-qualified strobe, read mux.
module sa_autosa_cacc_reg_group
  import sa_autosa_cacc_reg_pkg::*;
#(
  parameter int DIM_W    = 13,
  parameter int STRIDE_W = 24,
  parameter int ADDR_W   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [11:0]         i_offset,
  input  logic [31:0]         i_wr_data,
  input  logic                i_sat_we,
  input  logic [31:0]         i_sat_data,
  output cacc_ctl_t           o_ctl,
  output logic [DIM_W-1:0]    o_height,
  output logic [DIM_W-1:0]    o_width,
  output logic [DIM_W-1:0]    o_channel,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [STRIDE_W-1:0] o_line_stride,
  output logic [STRIDE_W-1:0] o_surf_stride,
  output logic [31:0]         o_rd_data
);

  cacc_ctl_t             r_ctl;
  logic [DIM_W-1:0]      r_height, r_width, r_channel;
  logic [ADDR_W-1:0]     r_addr;
  logic [STRIDE_W-1:0]   r_line_stride, r_surf_stride;
  logic [31:0]           r_sat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctl         <= CTL_RST;
      r_height      <= '0;
      r_width       <= '0;
      r_channel     <= '0;
      r_addr        <= '0;
      r_line_stride <= '0;
      r_surf_stride <= '0;
      r_sat         <= '0;
    end else begin
      if (i_wr_en) begin
        case (i_offset)
          OFF_MISC: begin
            r_ctl.proc_precision <= i_wr_data[MISC_PREC_LSB +: 2];
            r_ctl.cosa_mode      <= i_wr_data[0];
          end
          OFF_SIZE0: begin
            r_height <= i_wr_data[SIZE0_H_LSB +: DIM_W];
            r_width  <= i_wr_data[DIM_W-1:0];
          end
          OFF_SIZE1:     r_channel     <= i_wr_data[DIM_W-1:0];
          OFF_ADDR:      r_addr        <= i_wr_data[ADDR_W-1:0];
          OFF_BATCH:     r_ctl.batches <= i_wr_data[4:0];
          OFF_LINE_STRD: r_line_stride <= i_wr_data[STRIDE_W-1:0];
          OFF_SURF_STRD: r_surf_stride <= i_wr_data[STRIDE_W-1:0];
          OFF_MAP: begin
            r_ctl.line_packed <= i_wr_data[0];
            r_ctl.surf_packed <= i_wr_data[MAP_SURF_BIT];
          end
          OFF_CLIP:      r_ctl.clip_truncate <= i_wr_data[4:0];
          OFF_CYA:       r_ctl.cya           <= i_wr_data;
          default: ;
        endcase
      end
      if (i_sat_we) r_sat <= i_sat_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_offset)
      OFF_MISC: begin
        o_rd_data[MISC_PREC_LSB +: 2] = r_ctl.proc_precision;
        o_rd_data[0]                  = r_ctl.cosa_mode;
      end
      OFF_SIZE0: begin
        o_rd_data[SIZE0_H_LSB +: DIM_W] = r_height;
        o_rd_data[DIM_W-1:0]            = r_width;
      end
      OFF_SIZE1:     o_rd_data[DIM_W-1:0]    = r_channel;
      OFF_ADDR:      o_rd_data[ADDR_W-1:0]   = r_addr;
      OFF_BATCH:     o_rd_data[4:0]          = r_ctl.batches;
      OFF_LINE_STRD: o_rd_data[STRIDE_W-1:0] = r_line_stride;
      OFF_SURF_STRD: o_rd_data[STRIDE_W-1:0] = r_surf_stride;
      OFF_MAP: begin
        o_rd_data[0]            = r_ctl.line_packed;
        o_rd_data[MAP_SURF_BIT] = r_ctl.surf_packed;
      end
      OFF_CLIP:      o_rd_data[4:0] = r_ctl.clip_truncate;
      OFF_SAT:       o_rd_data      = r_sat;
      OFF_CYA:       o_rd_data      = r_ctl.cya;
      default: ;
    endcase
  end

  assign o_ctl         = r_ctl;
  assign o_height      = r_height;
  assign o_width       = r_width;
  assign o_channel     = r_channel;
  assign o_addr        = r_addr;
  assign o_line_stride = r_line_stride;
  assign o_surf_stride = r_surf_stride;

endmodule

// File: rtl/sa_autosa_cacc_reg_bank.sv
// N-deep ping-pong CACC config bank: producer/consumer pointers, op_en sequencing, write protection.
// Define AUTOSA_CACC_REG_IRQ_EN to add the S_INTR register (0x038) and the o_irq output.
module sa_autosa_cacc_reg_bank
  import sa_autosa_cacc_reg_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int DIM_W      = 13,
  parameter int STRIDE_W   = 24,
  parameter int ADDR_W     = 32
) (
  input  logic                i_autosa_core_clk,
  input  logic                i_autosa_core_rstn,
  input  logic [11:0]         i_reg_offset,
  input  logic                i_reg_wr_en,
  input  logic [31:0]         i_reg_wr_data,
  output logic [31:0]         o_reg_rd_data,
  input  logic                i_dp_op_done,
  input  logic [31:0]         i_dp_sat_count,
  output logic                o_dp_op_en,
  output logic                o_dp_op_start,
  output logic [4:0]          o_dp_cfg_batches,
  output logic [4:0]          o_dp_cfg_clip_truncate,
  output logic [31:0]         o_dp_cfg_cya,
  output logic [ADDR_W-1:0]   o_dp_cfg_dataout_addr,
  output logic                o_dp_cfg_line_packed,
  output logic                o_dp_cfg_surf_packed,
  output logic [DIM_W-1:0]    o_dp_cfg_dataout_height,
  output logic [DIM_W-1:0]    o_dp_cfg_dataout_width,
  output logic [DIM_W-1:0]    o_dp_cfg_dataout_channel,
  output logic [STRIDE_W-1:0] o_dp_cfg_line_stride,
  output logic [STRIDE_W-1:0] o_dp_cfg_surf_stride,
  output logic                o_dp_cfg_cosa_mode,
  output logic [1:0]          o_dp_cfg_proc_precision
`ifdef AUTOSA_CACC_REG_IRQ_EN
  ,output logic               o_irq
`endif
);

  localparam int               PTR_W    = $clog2(NUM_GROUPS);
  localparam logic [PTR_W-1:0] LAST_GRP = PTR_W'(NUM_GROUPS - 1);
  localparam logic [PTR_W:0]   NG_LIM   = (PTR_W + 1)'(NUM_GROUPS);

  logic [PTR_W-1:0]      r_prod, r_cons, w_cons_nxt;
  logic [NUM_GROUPS-1:0] r_op_en, w_op_en_nxt;
  logic                  r_wr_err, r_dp_op_en, r_dp_op_start;
  logic                  w_done_acc, w_field_wr, w_field_ok, w_err_set, w_err_clr, w_en_set, w_prod_wr;
  logic [31:0]           w_rd_data;

  cacc_ctl_t             w_ctl         [NUM_GROUPS];
  logic [DIM_W-1:0]      w_height      [NUM_GROUPS];
  logic [DIM_W-1:0]      w_width       [NUM_GROUPS];
  logic [DIM_W-1:0]      w_channel     [NUM_GROUPS];
  logic [ADDR_W-1:0]     w_addr        [NUM_GROUPS];
  logic [STRIDE_W-1:0]   w_line_stride [NUM_GROUPS];
  logic [STRIDE_W-1:0]   w_surf_stride [NUM_GROUPS];
  logic [31:0]           w_grp_rd      [NUM_GROUPS];

  assign w_done_acc = i_dp_op_done & r_op_en[r_cons];
  assign w_field_wr = i_reg_wr_en & is_group_field(i_reg_offset);
  assign w_field_ok = w_field_wr & ~r_op_en[r_prod];
  assign w_err_set  = (w_field_wr & r_op_en[r_prod]) | (i_dp_op_done & ~r_op_en[r_cons]);
  assign w_err_clr  = i_reg_wr_en & (i_reg_offset == OFF_S_STATUS) & i_reg_wr_data[STATUS_WR_ERR_BIT];
  assign w_en_set   = i_reg_wr_en & (i_reg_offset == OFF_OP_ENABLE) & i_reg_wr_data[0];
  assign w_prod_wr  = i_reg_wr_en & (i_reg_offset == OFF_S_POINTER)
                    & ({1'b0, i_reg_wr_data[PTR_W-1:0]} < NG_LIM);
  assign w_cons_nxt = !w_done_acc ? r_cons : (r_cons == LAST_GRP) ? '0 : r_cons + PTR_W'(1);

  // Done retires the consumer group first so a same-cycle enable of that group still lands.
  always_comb begin
    w_op_en_nxt = r_op_en;
    if (w_done_acc) w_op_en_nxt[r_cons] = 1'b0;
    if (w_en_set)   w_op_en_nxt[r_prod] = 1'b1;
  end

  always_ff @(posedge i_autosa_core_clk or negedge i_autosa_core_rstn) begin
    if (!i_autosa_core_rstn) begin
      r_prod        <= '0;
      r_cons        <= '0;
      r_op_en       <= '0;
      r_wr_err      <= 1'b0;
      r_dp_op_en    <= 1'b0;
      r_dp_op_start <= 1'b0;
    end else begin
      if (w_prod_wr) r_prod <= i_reg_wr_data[PTR_W-1:0];
      r_cons        <= w_cons_nxt;
      r_op_en       <= w_op_en_nxt;
      r_wr_err      <= w_err_set | (r_wr_err & ~w_err_clr);
      r_dp_op_en    <= w_op_en_nxt[w_cons_nxt];
      r_dp_op_start <= w_op_en_nxt[w_cons_nxt] & (w_done_acc | ~r_dp_op_en);
    end
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    sa_autosa_cacc_reg_group #(
      .DIM_W    (DIM_W),
      .STRIDE_W (STRIDE_W),
      .ADDR_W   (ADDR_W)
    ) u_grp (
      .i_clk         (i_autosa_core_clk),
      .i_rst_n       (i_autosa_core_rstn),
      .i_wr_en       (w_field_ok && (r_prod == PTR_W'(g))),
      .i_offset      (i_reg_offset),
      .i_wr_data     (i_reg_wr_data),
      .i_sat_we      (w_done_acc && (r_cons == PTR_W'(g))),
      .i_sat_data    (i_dp_sat_count),
      .o_ctl         (w_ctl[g]),
      .o_height      (w_height[g]),
      .o_width       (w_width[g]),
      .o_channel     (w_channel[g]),
      .o_addr        (w_addr[g]),
      .o_line_stride (w_line_stride[g]),
      .o_surf_stride (w_surf_stride[g]),
      .o_rd_data     (w_grp_rd[g])
    );
  end

`ifdef AUTOSA_CACC_REG_IRQ_EN
  logic [NUM_GROUPS-1:0] r_intr_done, w_intr_done_set, w_intr_done_nxt;
  logic                  r_intr_err, w_intr_err_nxt, r_irq, w_intr_wr;

  assign w_intr_wr = i_reg_wr_en & (i_reg_offset == OFF_S_INTR);

  // Set terms are OR'd after the W1C mask so a same-cycle event is never lost.
  always_comb begin
    w_intr_done_set = '0;
    if (w_done_acc) w_intr_done_set[r_cons] = 1'b1;
    w_intr_done_nxt = (r_intr_done & ~({NUM_GROUPS{w_intr_wr}} & i_reg_wr_data[NUM_GROUPS-1:0]))
                    | w_intr_done_set;
    w_intr_err_nxt  = (r_intr_err & ~(w_intr_wr & i_reg_wr_data[INTR_ERR_BIT])) | w_err_set;
  end

  always_ff @(posedge i_autosa_core_clk or negedge i_autosa_core_rstn) begin
    if (!i_autosa_core_rstn) begin
      r_intr_done <= '0;
      r_intr_err  <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_intr_done <= w_intr_done_nxt;
      r_intr_err  <= w_intr_err_nxt;
      r_irq       <= (|w_intr_done_nxt) | w_intr_err_nxt;
    end
  end

  assign o_irq = r_irq;
`endif

  always_comb begin
    w_rd_data = '0;
    case (i_reg_offset)
      OFF_S_STATUS: begin
        w_rd_data[NUM_GROUPS-1:0]      = r_op_en;
        w_rd_data[STATUS_WR_ERR_BIT]   = r_wr_err;
      end
      OFF_S_POINTER: begin
        w_rd_data[PTR_W-1:0]               = r_prod;
        w_rd_data[POINTER_CONS_LSB +: PTR_W] = r_cons;
      end
      OFF_OP_ENABLE: w_rd_data[0] = r_op_en[r_prod];
`ifdef AUTOSA_CACC_REG_IRQ_EN
      OFF_S_INTR: begin
        w_rd_data[NUM_GROUPS-1:0] = r_intr_done;
        w_rd_data[INTR_ERR_BIT]   = r_intr_err;
      end
`endif
      default: w_rd_data = w_grp_rd[r_prod];
    endcase
  end

  assign o_reg_rd_data            = w_rd_data;
  assign o_dp_op_en               = r_dp_op_en;
  assign o_dp_op_start            = r_dp_op_start;
  assign o_dp_cfg_batches         = w_ctl[r_cons].batches;
  assign o_dp_cfg_clip_truncate   = w_ctl[r_cons].clip_truncate;
  assign o_dp_cfg_cya             = w_ctl[r_cons].cya;
  assign o_dp_cfg_line_packed     = w_ctl[r_cons].line_packed;
  assign o_dp_cfg_surf_packed     = w_ctl[r_cons].surf_packed;
  assign o_dp_cfg_cosa_mode       = w_ctl[r_cons].cosa_mode;
  assign o_dp_cfg_proc_precision  = w_ctl[r_cons].proc_precision;
  assign o_dp_cfg_dataout_addr    = w_addr[r_cons];
  assign o_dp_cfg_dataout_height  = w_height[r_cons];
  assign o_dp_cfg_dataout_width   = w_width[r_cons];
  assign o_dp_cfg_dataout_channel = w_channel[r_cons];
  assign o_dp_cfg_line_stride     = w_line_stride[r_cons];
  assign o_dp_cfg_surf_stride     = w_surf_stride[r_cons];

endmodule

// File: tb/tb_sa_autosa_cacc_reg_bank.sv
// Self-checking bench for sa_autosa_cacc_reg_bank (NUM_GROUPS=2); register reads go through a scoreboard queue.
`timescale 1ns/1ps
module tb_sa_autosa_cacc_reg_bank;

  localparam int NG = 2, DIM_W = 13, STRIDE_W = 24, ADDR_W = 32;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [11:0]         offset = '0;
  logic                wr_en = 1'b0;
  logic [31:0]         wdata = '0;
  logic [31:0]         rd_data;
  logic                op_done = 1'b0;
  logic [31:0]         sat = '0;
  logic                op_en, op_start;
  logic [4:0]          batches, clip;
  logic [31:0]         cya;
  logic [ADDR_W-1:0]   addr;
  logic                line_packed, surf_packed, cosa;
  logic [DIM_W-1:0]    height, width, channel;
  logic [STRIDE_W-1:0] line_stride, surf_stride;
  logic [1:0]          prec;
`ifdef AUTOSA_CACC_REG_IRQ_EN
  logic                irq;
`endif

  typedef struct {
    string       name;
    logic [11:0] off;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int checks = 0, errors = 0, start_cnt = 0;

  sa_autosa_cacc_reg_bank #(.NUM_GROUPS(NG), .DIM_W(DIM_W), .STRIDE_W(STRIDE_W), .ADDR_W(ADDR_W)) dut (
    .i_autosa_core_clk        (clk),
    .i_autosa_core_rstn       (rstn),
    .i_reg_offset             (offset),
    .i_reg_wr_en              (wr_en),
    .i_reg_wr_data            (wdata),
    .o_reg_rd_data            (rd_data),
    .i_dp_op_done             (op_done),
    .i_dp_sat_count           (sat),
    .o_dp_op_en               (op_en),
    .o_dp_op_start            (op_start),
    .o_dp_cfg_batches         (batches),
    .o_dp_cfg_clip_truncate   (clip),
    .o_dp_cfg_cya             (cya),
    .o_dp_cfg_dataout_addr    (addr),
    .o_dp_cfg_line_packed     (line_packed),
    .o_dp_cfg_surf_packed     (surf_packed),
    .o_dp_cfg_dataout_height  (height),
    .o_dp_cfg_dataout_width   (width),
    .o_dp_cfg_dataout_channel (channel),
    .o_dp_cfg_line_stride     (line_stride),
    .o_dp_cfg_surf_stride     (surf_stride),
    .o_dp_cfg_cosa_mode       (cosa),
    .o_dp_cfg_proc_precision  (prec)
`ifdef AUTOSA_CACC_REG_IRQ_EN
    ,.o_irq                   (irq)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (op_start === 1'b1) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr(input logic [11:0] off, input logic [31:0] data);
    @(negedge clk);
    offset = off; wdata = data; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [11:0] off, output logic [31:0] got);
    @(negedge clk);
    offset = off;
    #1;
    got = rd_data;
  endtask

  task automatic done_pulse(input logic [31:0] s);
    @(negedge clk);
    op_done = 1'b1; sat = s;
    @(negedge clk);
    op_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (op_en !== 1'b0 || op_start !== 1'b0) begin
      errors++; $display("FAIL reset_dp: op_en=%b op_start=%b want 0 0", op_en, op_start);
    end
    checks++;
    if (prec !== 2'b01 || height !== '0) begin
      errors++; $display("FAIL reset_cfg: prec=%b height=%0d want 01 0", prec, height);
    end
    for (int a = 0; a <= 14; a++)
      sb_q.push_back('{$sformatf("reset_rd_%03h", a * 4), 12'(a * 4), (a == 3) ? 32'h0000_1000 : 32'h0});
    wr(12'h030, 32'h0000_ffff);
    sb_q.push_back('{"sat_ro", 12'h030, 32'h0});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_op_start();
    logic [31:0] got;
    int s0;
    s0 = start_cnt;
    wr(12'h010, 32'h0010_0020);
    wr(12'h008, 32'h1);
    checks++;
    if (op_en !== 1'b1 || op_start !== 1'b1) begin
      errors++; $display("FAIL enable_edge: op_en=%b op_start=%b want 1 1", op_en, op_start);
    end
    @(negedge clk);
    checks++;
    if (op_start !== 1'b0) begin errors++; $display("FAIL start_width: op_start=%b want 0", op_start); end
    repeat (2) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL start_count: got %0d want 1", start_cnt - s0); end
    checks++;
    if (height !== 13'd16 || width !== 13'd32) begin
      errors++; $display("FAIL cfg_size: h=%0d w=%0d want 16 32", height, width);
    end
    sb_q.push_back('{"status_en0", 12'h000, 32'h1});
    sb_q.push_back('{"op_enable_rd", 12'h008, 32'h1});
    sb_q.push_back('{"size0_rd", 12'h010, 32'h0010_0020});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_wr_protect();
    logic [31:0] got;
    wr(12'h020, 32'h0000_0123);
    checks++;
    if (line_stride !== '0) begin errors++; $display("FAIL prot_out: line_stride=%h want 0", line_stride); end
    sb_q.push_back('{"prot_field", 12'h020, 32'h0});
    sb_q.push_back('{"prot_err", 12'h000, 32'h0001_0001});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
    wr(12'h000, 32'h0001_0000);
    sb_q.push_back('{"err_w1c", 12'h000, 32'h1});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_ping_pong();
    logic [31:0] got;
    int s0;
    wr(12'h004, 32'h1);
    wr(12'h010, 32'h0005_0006);
    wr(12'h014, 32'h7);
    wr(12'h018, 32'hdead_0000);
    wr(12'h00c, 32'h0000_2001);
    s0 = start_cnt;
    wr(12'h008, 32'h1);
    @(negedge clk);
    checks++;
    if (start_cnt != s0 || height !== 13'd16) begin
      errors++; $display("FAIL pp_hold: starts=%0d height=%0d want 0 16", start_cnt - s0, height);
    end
    done_pulse(32'd7);
    checks++;
    if (op_start !== 1'b1 || op_en !== 1'b1) begin
      errors++; $display("FAIL pp_advance: op_start=%b op_en=%b want 1 1", op_start, op_en);
    end
    checks++;
    if (height !== 13'd5 || width !== 13'd6 || channel !== 13'd7 || addr !== 32'hdead_0000) begin
      errors++; $display("FAIL pp_cfg: h=%0d w=%0d c=%0d a=%h want 5 6 7 dead0000", height, width, channel, addr);
    end
    checks++;
    if (prec !== 2'd2 || cosa !== 1'b1) begin
      errors++; $display("FAIL pp_misc: prec=%0d cosa=%b want 2 1", prec, cosa);
    end
    sb_q.push_back('{"pp_pointer", 12'h004, 32'h0001_0001});
    sb_q.push_back('{"pp_status", 12'h000, 32'h2});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
    wr(12'h004, 32'h0);
    sb_q.push_back('{"sat_g0", 12'h030, 32'd7});
    sb_q.push_back('{"misc_g0", 12'h00c, 32'h0000_1000});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
    done_pulse(32'd9);
    checks++;
    if (op_en !== 1'b0 || op_start !== 1'b0) begin
      errors++; $display("FAIL pp_wrap: op_en=%b op_start=%b want 0 0", op_en, op_start);
    end
    sb_q.push_back('{"pp_pointer_wrap", 12'h004, 32'h0});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
    wr(12'h004, 32'h1);
    sb_q.push_back('{"sat_g1", 12'h030, 32'd9});
    sb_q.push_back('{"status_idle", 12'h000, 32'h0});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_bad_done();
    logic [31:0] got;
`ifdef AUTOSA_CACC_REG_IRQ_EN
    wr(12'h038, 32'h0001_0003);
`endif
    done_pulse(32'd5);
`ifdef AUTOSA_CACC_REG_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: irq=%b want 1", irq); end
    sb_q.push_back('{"intr_err", 12'h038, 32'h0001_0000});
`endif
    sb_q.push_back('{"bad_pointer", 12'h004, 32'h1});
    sb_q.push_back('{"bad_err", 12'h000, 32'h0001_0000});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
`ifdef AUTOSA_CACC_REG_IRQ_EN
    wr(12'h038, 32'h0001_0000);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: irq=%b want 0", irq); end
`endif
    wr(12'h000, 32'h0001_0000);
    sb_q.push_back('{"bad_err_clr", 12'h000, 32'h0});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] got;
    wr(12'h004, 32'h0);
    wr(12'h008, 32'h1);
    @(negedge clk);
    op_done = 1'b1; sat = 32'd3;
    offset = 12'h008; wdata = 32'h1; wr_en = 1'b1;
    @(negedge clk);
    op_done = 1'b0; wr_en = 1'b0;
    checks++;
    if (op_en !== 1'b0) begin errors++; $display("FAIL same_op_en: op_en=%b want 0", op_en); end
    sb_q.push_back('{"same_status", 12'h000, 32'h1});
    sb_q.push_back('{"same_pointer", 12'h004, 32'h0001_0000});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] got;
    wr(12'h004, 32'h1);
    wr(12'h008, 32'h1);
    checks++;
    if (op_en !== 1'b1 || height !== 13'd5) begin
      errors++; $display("FAIL mid_pre: op_en=%b height=%0d want 1 5", op_en, height);
    end
    sb_q.push_back('{"mid_status", 12'h000, 32'h3});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (op_en !== 1'b0 || height !== '0 || width !== '0 || prec !== 2'b01) begin
      errors++; $display("FAIL async_rst: op_en=%b h=%0d w=%0d prec=%b want 0 0 0 01", op_en, height, width, prec);
    end
    offset = 12'h004;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("FAIL async_rst_ptr: got %h want 0", rd_data); end
    @(negedge clk);
    rstn = 1'b1;
    sb_q.push_back('{"post_rst_size0", 12'h010, 32'h0});
    sb_q.push_back('{"post_rst_status", 12'h000, 32'h0});
    while (sb_q.size() > 0) begin
      rd_exp_t e = sb_q.pop_front();
      read_reg(e.off, got);
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_op_start();
    test_wr_protect();
    test_ping_pong();
    test_bad_done();
    test_same_cycle();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
